// File: rtl/yolo_pkg.sv
// yolo_pkg: shared image geometry, pixel type and ingest FSM states
package yolo_pkg;
  localparam int IMG_W = 416;
  localparam int IMG_H = 416;
  localparam int DATA_W = 24;
  localparam int COORD_W = 11;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} ingest_state_t;
endpackage

// File: rtl/pixel_stream_ingest_if.sv
// pixel_stream_ingest_if: raster pixel stream with valid/ready, start-of-frame and end-of-line
interface pixel_stream_ingest_if #(parameter int DATA_W = yolo_pkg::DATA_W);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  logic sof;
  logic eol;
  modport master(output valid, data, sof, eol, input ready);
  modport slave(input valid, data, sof, eol, output ready);
endinterface

// File: rtl/pixel_stream_ingest_raster_coord_counter.sv
// raster_coord_counter: x/y raster position with SOF restart, EOL/width wrap and last-pixel flag
module raster_coord_counter #(
  parameter int IMG_W = yolo_pkg::IMG_W,
  parameter int IMG_H = yolo_pkg::IMG_H,
  parameter int COORD_W = yolo_pkg::COORD_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic restart,
  input  logic eol,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic line_end,
  output logic last
);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H - 1);
  logic [COORD_W-1:0] x_q, y_q;
  // x/y are the position of the beat being presented; SOF forces it to the origin
  assign x = restart ? '0 : x_q;
  assign y = restart ? '0 : y_q;
  assign line_end = x == X_MAX;
  assign last = line_end && y == Y_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step) begin
      x_q <= (line_end || eol) ? '0 : x + 1'b1;
      y_q <= last ? '0 : ((line_end || eol) && y != Y_MAX) ? y + 1'b1 : y;
    end
endmodule

// File: rtl/pixel_stream_ingest.sv
// pixel_stream_ingest: raster stream to input-buffer write port with framing checks.
// Define PIXEL_INGEST_ERRCNT_EN to add a saturating err_count output.
module pixel_stream_ingest #(
  parameter int IMG_W = yolo_pkg::IMG_W,
  parameter int IMG_H = yolo_pkg::IMG_H,
  parameter int DATA_W = yolo_pkg::DATA_W,
  parameter int COORD_W = yolo_pkg::COORD_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_enable,
  pixel_stream_ingest_if.slave s,
  output logic [DATA_W-1:0] pixel_data,
  output logic [COORD_W-1:0] x_coord,
  output logic [COORD_W-1:0] y_coord,
  output logic write_enable,
  output logic frame_done,
  output logic err_sof,
  output logic err_eol,
`ifdef PIXEL_INGEST_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic busy
);
  import yolo_pkg::*;
  ingest_state_t state;
  logic acc, wr, line_end, last;
  logic [COORD_W-1:0] cx, cy;
  assign s.ready = frame_enable && state != DONE;
  assign acc = s.valid && s.ready;
  assign wr = acc && (s.sof || state == ACTIVE);
  assign busy = state == ACTIVE;
  raster_coord_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .step(wr), .restart(s.sof), .eol(s.eol),
    .x(cx), .y(cy), .line_end(line_end), .last(last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pixel_data <= '0;
      x_coord <= '0;
      y_coord <= '0;
      write_enable <= 1'b0;
      frame_done <= 1'b0;
      err_sof <= 1'b0;
      err_eol <= 1'b0;
    end else begin
      write_enable <= wr;
      frame_done <= state == DONE;
      err_sof <= acc && s.sof && state == ACTIVE;
      err_eol <= wr && (s.eol != line_end);
      if (wr) begin
        pixel_data <= s.data;
        x_coord <= cx;
        y_coord <= cy;
      end
      state <= state == DONE ? IDLE : wr ? (last ? DONE : ACTIVE) : state;
    end
`ifdef PIXEL_INGEST_ERRCNT_EN
  logic [16:0] err_sum;
  assign err_sum = 17'(err_count) + 17'(err_sof) + 17'(err_eol);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
endmodule

// File: tb/tb_pixel_stream_ingest.sv
// tb_pixel_stream_ingest: directed tests on a 4x2 image
module tb_pixel_stream_ingest;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_enable = 1'b0;
  logic [23:0] pixel_data;
  logic [10:0] x_coord, y_coord;
  logic write_enable, frame_done, err_sof, err_eol, busy;
`ifdef PIXEL_INGEST_ERRCNT_EN
  logic [15:0] err_count;
`endif
  int tests = 0;
  int fails = 0;
  pixel_stream_ingest_if #(.DATA_W(24)) s();
  pixel_stream_ingest #(.IMG_W(4), .IMG_H(2), .DATA_W(24), .COORD_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .frame_enable(frame_enable), .s(s),
    .pixel_data(pixel_data), .x_coord(x_coord), .y_coord(y_coord),
    .write_enable(write_enable), .frame_done(frame_done),
    .err_sof(err_sof), .err_eol(err_eol),
`ifdef PIXEL_INGEST_ERRCNT_EN
    .err_count(err_count),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic beat(input logic [23:0] d, input logic sof, input logic eol);
    @(negedge clk);
    s.valid = 1'b1;
    s.data = d;
    s.sof = sof;
    s.eol = eol;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    s.valid = 1'b0;
    s.sof = 1'b0;
    s.eol = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s.valid = 1'b0;
    s.data = '0;
    s.sof = 1'b0;
    s.eol = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({write_enable, frame_done, err_sof, err_eol, busy, s.ready} !== 6'b0 || pixel_data !== 24'h0 || x_coord !== 11'd0 || y_coord !== 11'd0) begin
      fails++;
      $display("FAIL reset we=%b fd=%b es=%b ee=%b busy=%b rdy=%b data=%h x=%0d y=%0d, want all 0", write_enable, frame_done, err_sof, err_eol, busy, s.ready, pixel_data, x_coord, y_coord);
    end
    @(negedge clk);
    rst_n = 1'b1;
    frame_enable = 1'b1;
    #1;
    tests++;
    if (s.ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready got %b want 1", s.ready);
    end
  endtask

  task automatic test_clean_frame();
    for (int i = 0; i < 8; i++) begin
      beat(24'h100000 + 24'(i), i == 0, i % 4 == 3);
      tests++;
      if (write_enable !== 1'b1 || x_coord !== 11'(i % 4) || y_coord !== 11'(i / 4) || pixel_data !== 24'h100000 + 24'(i) || err_sof !== 1'b0 || err_eol !== 1'b0 || busy !== (i < 7)) begin
        fails++;
        $display("FAIL clean_beat%0d we=%b x=%0d y=%0d data=%h es=%b ee=%b busy=%b want we=1 x=%0d y=%0d data=%h no err busy=%b", i, write_enable, x_coord, y_coord, pixel_data, err_sof, err_eol, busy, i % 4, i / 4, 24'h100000 + 24'(i), i < 7);
      end
    end
    tests++;
    if (s.ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL clean_done_state rdy=%b busy=%b fd=%b want 0 0 0", s.ready, busy, frame_done);
    end
    idle();
    tests++;
    if (frame_done !== 1'b1 || write_enable !== 1'b0) begin
      fails++;
      $display("FAIL clean_frame_done fd=%b we=%b want 1 0", frame_done, write_enable);
    end
    idle();
    tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || s.ready !== 1'b1) begin
      fails++;
      $display("FAIL clean_after fd=%b busy=%b rdy=%b want 0 0 1", frame_done, busy, s.ready);
    end
  endtask

  task automatic test_pre_sof();
    for (int i = 0; i < 3; i++) begin
      beat(24'hBAD000 + 24'(i), 1'b0, i == 2);
      tests++;
      if (write_enable !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL garbage%0d we=%b busy=%b want 0 0", i, write_enable, busy);
      end
    end
    for (int i = 0; i < 8; i++) begin
      beat(24'h200000 + 24'(i), i == 0, i % 4 == 3);
      tests++;
      if (write_enable !== 1'b1 || x_coord !== 11'(i % 4) || y_coord !== 11'(i / 4) || pixel_data !== 24'h200000 + 24'(i)) begin
        fails++;
        $display("FAIL presof_beat%0d we=%b x=%0d y=%0d data=%h want 1 %0d %0d %h", i, write_enable, x_coord, y_coord, pixel_data, i % 4, i / 4, 24'h200000 + 24'(i));
      end
    end
    idle();
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL presof_frame_done got %b want 1", frame_done);
    end
  endtask

  task automatic test_early_eol();
    beat(24'h300000, 1'b1, 1'b0);
    beat(24'h300001, 1'b0, 1'b1);
    tests++;
    if (write_enable !== 1'b1 || x_coord !== 11'd1 || y_coord !== 11'd0 || err_eol !== 1'b1 || err_sof !== 1'b0) begin
      fails++;
      $display("FAIL early_eol we=%b x=%0d y=%0d ee=%b es=%b want 1 1 0 1 0", write_enable, x_coord, y_coord, err_eol, err_sof);
    end
    for (int j = 0; j < 4; j++) begin
      beat(24'h300010 + 24'(j), 1'b0, j == 3);
      tests++;
      if (write_enable !== 1'b1 || x_coord !== 11'(j) || y_coord !== 11'd1 || err_eol !== 1'b0 || pixel_data !== 24'h300010 + 24'(j)) begin
        fails++;
        $display("FAIL early_eol_line1_%0d we=%b x=%0d y=%0d ee=%b data=%h want 1 %0d 1 0 %h", j, write_enable, x_coord, y_coord, err_eol, pixel_data, j, 24'h300010 + 24'(j));
      end
    end
    idle();
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL early_eol_frame_done got %b want 1", frame_done);
    end
`ifdef PIXEL_INGEST_ERRCNT_EN
    tests++;
    if (err_count !== 16'd1) begin
      fails++;
      $display("FAIL errcnt_after_eol got %0d want 1", err_count);
    end
`endif
  endtask

  task automatic test_mid_sof();
    beat(24'h400000, 1'b1, 1'b0);
    beat(24'h400001, 1'b0, 1'b0);
    beat(24'h400002, 1'b1, 1'b0);
    tests++;
    if (write_enable !== 1'b1 || x_coord !== 11'd0 || y_coord !== 11'd0 || err_sof !== 1'b1 || err_eol !== 1'b0 || pixel_data !== 24'h400002 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_sof we=%b x=%0d y=%0d es=%b ee=%b data=%h busy=%b want 1 0 0 1 0 400002 1", write_enable, x_coord, y_coord, err_sof, err_eol, pixel_data, busy);
    end
    for (int j = 1; j < 8; j++) begin
      beat(24'h400010 + 24'(j), 1'b0, j % 4 == 3);
      tests++;
      if (write_enable !== 1'b1 || x_coord !== 11'(j % 4) || y_coord !== 11'(j / 4) || err_sof !== 1'b0 || err_eol !== 1'b0) begin
        fails++;
        $display("FAIL mid_sof_beat%0d we=%b x=%0d y=%0d es=%b ee=%b want 1 %0d %0d 0 0", j, write_enable, x_coord, y_coord, err_sof, err_eol, j % 4, j / 4);
      end
    end
    idle();
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL mid_sof_frame_done got %b want 1", frame_done);
    end
`ifdef PIXEL_INGEST_ERRCNT_EN
    tests++;
    if (err_count !== 16'd2) begin
      fails++;
      $display("FAIL errcnt_two got %0d want 2", err_count);
    end
`endif
  endtask

  task automatic test_missing_eol();
    for (int i = 0; i < 8; i++) begin
      beat(24'h500000 + 24'(i), i == 0, i == 7);
      tests++;
      if (write_enable !== 1'b1 || x_coord !== 11'(i % 4) || y_coord !== 11'(i / 4) || err_eol !== (i == 3)) begin
        fails++;
        $display("FAIL missing_eol_beat%0d we=%b x=%0d y=%0d ee=%b want 1 %0d %0d %b", i, write_enable, x_coord, y_coord, err_eol, i % 4, i / 4, i == 3);
      end
    end
    idle();
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL missing_eol_frame_done got %b want 1", frame_done);
    end
  endtask

  task automatic test_enable_reset();
    beat(24'h600000, 1'b1, 1'b0);
    beat(24'h600001, 1'b0, 1'b0);
    @(negedge clk);
    frame_enable = 1'b0;
    s.data = 24'h600002;
    s.sof = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      tests++;
      if (s.ready !== 1'b0 || write_enable !== 1'b0 || x_coord !== 11'd1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL enable_low%0d rdy=%b we=%b x=%0d busy=%b want 0 0 1 1", k, s.ready, write_enable, x_coord, busy);
      end
    end
    @(negedge clk);
    frame_enable = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (write_enable !== 1'b1 || x_coord !== 11'd2 || y_coord !== 11'd0 || pixel_data !== 24'h600002) begin
      fails++;
      $display("FAIL enable_resume we=%b x=%0d y=%0d data=%h want 1 2 0 600002", write_enable, x_coord, y_coord, pixel_data);
    end
    @(negedge clk);
    s.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({write_enable, frame_done, err_sof, err_eol, busy} !== 5'b0 || pixel_data !== 24'h0 || x_coord !== 11'd0 || y_coord !== 11'd0) begin
      fails++;
      $display("FAIL async_reset we=%b fd=%b es=%b ee=%b busy=%b data=%h x=%0d y=%0d want all 0", write_enable, frame_done, err_sof, err_eol, busy, pixel_data, x_coord, y_coord);
    end
`ifdef PIXEL_INGEST_ERRCNT_EN
    tests++;
    if (err_count !== 16'd0) begin
      fails++;
      $display("FAIL errcnt_reset got %0d want 0", err_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    beat(24'h700000, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_ignore we=%b busy=%b want 0 0", write_enable, busy);
    end
    beat(24'h700001, 1'b1, 1'b0);
    tests++;
    if (write_enable !== 1'b1 || x_coord !== 11'd0 || y_coord !== 11'd0 || pixel_data !== 24'h700001 || busy !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_sof we=%b x=%0d y=%0d data=%h busy=%b want 1 0 0 700001 1", write_enable, x_coord, y_coord, pixel_data, busy);
    end
    beat(24'h700002, 1'b0, 1'b0);
    tests++;
    if (write_enable !== 1'b1 || x_coord !== 11'd1 || y_coord !== 11'd0) begin
      fails++;
      $display("FAIL post_reset_next we=%b x=%0d y=%0d want 1 1 0", write_enable, x_coord, y_coord);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_pre_sof();
    test_early_eol();
    test_mid_sof();
    test_missing_eol();
    test_enable_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
